fm_wm_scheduler: RTL and testbench

- Sequencing controller for the feature×weight transformation datapath of the GCN accelerator.
- Owns the single read port of the shared feature/weight memory.
- Loads all weight columns, then streams one feature row at a time.
- For each (row, col) pair: issues a dot-product request, waits for completion, and strobes the result into the FM·WM output buffer. Signals done when all FEATURE_ROWS×WEIGHT_COLS products are written.

---
 rtl/gcn_pkg.sv | 23 ++
 rtl/fm_wm_scheduler_if.sv | 30 +++
 rtl/gcn_idx_counter.sv | 36 +++
 rtl/fm_wm_scheduler.sv | 137 +++++++++++++
 tb/tb_fm_wm_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN feature x weight sequencing logic.
package gcn_pkg;

  localparam int DEFAULT_FEATURE_ROWS = 6;
  localparam int DEFAULT_WEIGHT_COLS  = 3;
  localparam logic [12:0] FEATURE_BASE_ADDR = 13'h200;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_F,
    MAC_ISSUE,
    MAC_WAIT,
    WRITE,
    DONE
  } state_t;

  // A single-entry range still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fm_wm_scheduler_if.sv
// Control/memory/MAC handshake bundle between the scheduler and its datapath.
interface fm_wm_scheduler_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int ROW_W         = 3,
  parameter int COL_W         = 2
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     enable_read;
  logic                     weight_load;
  logic                     feature_load;
  logic [COL_W-1:0]         weight_col;
  logic [ROW_W-1:0]         feature_row;
  logic                     mac_start;
  logic                     mac_done;
  logic                     write_enable;
  logic                     done;

  modport master (
    input  start, mac_done,
    output read_address, enable_read, weight_load, feature_load,
           weight_col, feature_row, mac_start, write_enable, done
  );

  modport slave (
    output start, mac_done,
    input  read_address, enable_read, weight_load, feature_load,
           weight_col, feature_row, mac_start, write_enable, done
  );
endinterface

// File: rtl/gcn_idx_counter.sv
// Bounded up-counter: clear wins over enable, holds at MAX-1 and flags it.
module gcn_idx_counter
  import gcn_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = idx_width(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == W'(MAX - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fm_wm_scheduler.sv
// Sequencer for the feature x weight product: loads weights, then per row issues
// one dot product per column and strobes each result into the output buffer.
module fm_wm_scheduler
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS  = DEFAULT_FEATURE_ROWS,
  parameter int WEIGHT_COLS   = DEFAULT_WEIGHT_COLS,
  parameter int ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = ADDRESS_WIDTH'(FEATURE_BASE_ADDR),
  parameter int ROW_W         = idx_width(FEATURE_ROWS),
  parameter int COL_W         = idx_width(WEIGHT_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  fm_wm_scheduler_if.master bus
);
  state_t           state_q, state_d;
  logic             row_clr, row_en, row_last;
  logic             col_clr, col_en, col_last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     en_rd, wl, fl, ms, we, dn;
  logic [COL_W-1:0]         wc;
  logic [ROW_W-1:0]         fr;

  gcn_idx_counter #(.MAX(FEATURE_ROWS), .W(ROW_W)) u_row (
    .clk(clk), .rst_n(reset), .clr_i(row_clr), .en_i(row_en),
    .cnt_o(row), .last_o(row_last)
  );

  gcn_idx_counter #(.MAX(WEIGHT_COLS), .W(COL_W)) u_col (
    .clk(clk), .rst_n(reset), .clr_i(col_clr), .en_i(col_en),
    .cnt_o(col), .last_o(col_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode only state_q and counter registers, never an input.
  always_comb begin
    state_d = state_q;
    row_clr = 1'b0;
    row_en  = 1'b0;
    col_clr = 1'b0;
    col_en  = 1'b0;
    rd_addr = '0;
    en_rd   = 1'b0;
    wl      = 1'b0;
    fl      = 1'b0;
    ms      = 1'b0;
    we      = 1'b0;
    dn      = 1'b0;
    wc      = '0;
    fr      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_W;
          row_clr = 1'b1;
          col_clr = 1'b1;
        end
      end
      LOAD_W: begin
        en_rd   = 1'b1;
        wl      = 1'b1;
        rd_addr = ADDRESS_WIDTH'(col);
        wc      = col;
        if (col_last) begin
          state_d = LOAD_F;
          row_clr = 1'b1;
          col_clr = 1'b1;
        end else begin
          col_en = 1'b1;
        end
      end
      LOAD_F: begin
        en_rd   = 1'b1;
        fl      = 1'b1;
        rd_addr = FEATURE_BASE + ADDRESS_WIDTH'(row);
        fr      = row;
        state_d = MAC_ISSUE;
      end
      MAC_ISSUE: begin
        ms      = 1'b1;
        wc      = col;
        fr      = row;
        state_d = MAC_WAIT;
      end
      MAC_WAIT: begin
        wc = col;
        fr = row;
        if (bus.mac_done) state_d = WRITE;
      end
      WRITE: begin
        we = 1'b1;
        wc = col;
        fr = row;
        if (!col_last) begin
          col_en  = 1'b1;
          state_d = MAC_ISSUE;
        end else if (!row_last) begin
          row_en  = 1'b1;
          col_clr = 1'b1;
          state_d = LOAD_F;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        dn = 1'b1;
        if (!bus.start) begin
          state_d = IDLE;
          row_clr = 1'b1;
          col_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_address = rd_addr;
  assign bus.enable_read  = en_rd;
  assign bus.weight_load  = wl;
  assign bus.feature_load = fl;
  assign bus.mac_start    = ms;
  assign bus.write_enable = we;
  assign bus.done         = dn;
  assign bus.weight_col   = wc;
  assign bus.feature_row  = fr;
endmodule

// File: tb/tb_fm_wm_scheduler.sv
// Directed bench: default 6x3 scheduler plus a 1x1 instance, with MAC responders.
module tb_fm_wm_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fm_wm_scheduler_if #(.ADDRESS_WIDTH(13), .ROW_W(3), .COL_W(2)) bus_a ();
  fm_wm_scheduler_if #(.ADDRESS_WIDTH(13), .ROW_W(1), .COL_W(1)) bus_b ();

  fm_wm_scheduler dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fm_wm_scheduler #(.FEATURE_ROWS(1), .WEIGHT_COLS(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [12:0] rd_a[$];
  int wr_a[$];
  int gap_a[$];
  int wl_a, fl_a, ms_a, overlap_a, done_cyc_a, last_ms_a, pend_a;
  bit outstanding_a;
  int lat_mode = 0;
  int lat_fixed = 1;
  bit spurious = 1'b0;

  logic [12:0] rd_b[$];
  int wr_b[$];
  int done_cyc_b;
  bit prev_ms_b;

  // Responder and event log for the 6x3 instance; samples 1 time unit after each edge.
  initial begin
    bit pulse;
    bus_a.mac_done = 1'b0;
    pend_a = 0;
    outstanding_a = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        pend_a = 0;
        outstanding_a = 1'b0;
        bus_a.mac_done = 1'b0;
      end else begin
        pulse = 1'b0;
        if (pend_a > 0) begin
          pend_a--;
          if (pend_a == 0) begin
            pulse = 1'b1;
            outstanding_a = 1'b0;
          end
        end
        if (bus_a.enable_read) rd_a.push_back(bus_a.read_address);
        if (bus_a.weight_load) wl_a++;
        if (bus_a.feature_load) fl_a++;
        if (bus_a.write_enable) begin
          wr_a.push_back(int'(bus_a.feature_row) * 16 + int'(bus_a.weight_col));
          gap_a.push_back(cyc - last_ms_a);
        end
        if (bus_a.done && done_cyc_a < 0) done_cyc_a = cyc;
        if (bus_a.mac_start) begin
          ms_a++;
          if (outstanding_a) overlap_a++;
          outstanding_a = 1'b1;
          last_ms_a = cyc;
          pend_a = (lat_mode != 0) ? int'($urandom_range(7, 1)) : lat_fixed;
        end
        bus_a.mac_done = pulse | (spurious & (bus_a.feature_load | bus_a.mac_start));
      end
    end
  end

  // 1x1 instance: mac_done exactly one cycle after mac_start.
  initial begin
    bus_b.mac_done = 1'b0;
    prev_ms_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_ms_b = 1'b0;
        bus_b.mac_done = 1'b0;
      end else begin
        if (bus_b.enable_read) rd_b.push_back(bus_b.read_address);
        if (bus_b.write_enable) wr_b.push_back(int'(bus_b.feature_row) * 16 + int'(bus_b.weight_col));
        if (bus_b.done && done_cyc_b < 0) done_cyc_b = cyc;
        bus_b.mac_done = prev_ms_b;
        prev_ms_b = bus_b.mac_start;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] outs_a();
    return {bus_a.read_address, bus_a.enable_read, bus_a.weight_load, bus_a.feature_load,
            bus_a.weight_col, bus_a.feature_row, bus_a.mac_start, bus_a.write_enable, bus_a.done};
  endfunction

  function automatic logic [20:0] outs_b();
    return {bus_b.read_address, bus_b.enable_read, bus_b.weight_load, bus_b.feature_load,
            bus_b.weight_col, bus_b.feature_row, bus_b.mac_start, bus_b.write_enable, bus_b.done};
  endfunction

  // Number of writes out of (row,col) order; a wrong count is reported separately.
  function automatic int order_errs_a();
    int n = 0;
    if (wr_a.size() != 18) return 99;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 3; c++)
        if (wr_a[r * 3 + c] != r * 16 + c) n++;
    return n;
  endfunction

  task automatic clear_a();
    rd_a.delete();
    wr_a.delete();
    gap_a.delete();
    wl_a = 0;
    fl_a = 0;
    ms_a = 0;
    overlap_a = 0;
    done_cyc_a = -1;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_a.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    clear_a();
    rd_b.delete();
    wr_b.delete();
    done_cyc_b = -1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a() !== 24'h0) begin
      errors++;
      $display("FAIL reset_outs_a: got %h, required 0", outs_a());
    end
    checks++;
    if (outs_b() !== 21'h0) begin
      errors++;
      $display("FAIL reset_outs_b: got %h, required 0", outs_b());
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a() !== 24'h0 || rd_a.size() != 0) begin
      errors++;
      $display("FAIL idle_no_start: outs %h reads %0d, required 0 and 0", outs_a(), rd_a.size());
    end
    $display("test_reset: done");
  endtask

  task automatic test_nominal();
    bit ok;
    int s, bad;
    clear_a();
    lat_mode = 0;
    lat_fixed = 1;
    spurious = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    s = cyc + 1;
    wait_done_a(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nominal_done: done=%0b, required 1 within 200 cycles", bus_a.done);
    end
    checks++;
    if (rd_a.size() != 9) begin
      errors++;
      $display("FAIL nominal_read_count: got %0d, required 9", rd_a.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++) if (rd_a[i] != 13'(i)) bad++;
      for (int r = 0; r < 6; r++) if (rd_a[3 + r] != 13'h200 + 13'(r)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL nominal_read_addrs: %0d wrong, first four %h %h %h %h, required 000 001 002 200",
                 bad, rd_a[0], rd_a[1], rd_a[2], rd_a[3]);
      end
    end
    checks++;
    if (wl_a != 3 || fl_a != 6) begin
      errors++;
      $display("FAIL nominal_loads: weight %0d feature %0d, required 3 and 6", wl_a, fl_a);
    end
    checks++;
    if (order_errs_a() != 0) begin
      errors++;
      $display("FAIL nominal_writes: %0d writes, %0d misordered, required 18 in order", wr_a.size(), order_errs_a());
    end
    checks++;
    if (ms_a != 18) begin
      errors++;
      $display("FAIL nominal_mac_starts: got %0d, required 18", ms_a);
    end
    checks++;
    if (done_cyc_a - s != 63) begin
      errors++;
      $display("FAIL nominal_latency: done after %0d edges, required 63", done_cyc_a - s);
    end
    $display("test_nominal: %0d writes, done after %0d edges", wr_a.size(), done_cyc_a - s);
  endtask

  task automatic test_done_hold();
    bit ok;
    int low;
    clear_a();
    low = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus_a.done) low++;
    end
    checks++;
    if (low != 0 || rd_a.size() != 0 || ms_a != 0) begin
      errors++;
      $display("FAIL done_hold: done low %0d cycles, reads %0d, mac_starts %0d, required 0 0 0",
               low, rd_a.size(), ms_a);
    end
    bus_a.start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_a() !== 24'h0) begin
      errors++;
      $display("FAIL done_release: outs %h, required 0 (IDLE)", outs_a());
    end
    clear_a();
    bus_a.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.enable_read !== 1'b1 || bus_a.weight_load !== 1'b1 || bus_a.read_address !== 13'h0) begin
      errors++;
      $display("FAIL restart_first_read: en %0b wl %0b addr %h, required 1 1 000",
               bus_a.enable_read, bus_a.weight_load, bus_a.read_address);
    end
    wait_done_a(200, ok);
    checks++;
    if (!ok || order_errs_a() != 0) begin
      errors++;
      $display("FAIL restart_run: done %0b writes %0d, required 1 and 18 in order", ok, wr_a.size());
    end
    bus_a.start = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_done_hold: restart writes %0d", wr_a.size());
  endtask

  task automatic test_variable_latency();
    bit ok;
    clear_a();
    lat_mode = 1;
    @(negedge clk);
    bus_a.start = 1'b1;
    wait_done_a(800, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL varlat_done: done=%0b, required 1 within 800 cycles", bus_a.done);
    end
    checks++;
    if (order_errs_a() != 0) begin
      errors++;
      $display("FAIL varlat_writes: %0d writes, %0d misordered, required 18 in order", wr_a.size(), order_errs_a());
    end
    checks++;
    if (ms_a != 18 || overlap_a != 0) begin
      errors++;
      $display("FAIL varlat_mac_starts: count %0d overlaps %0d, required 18 and 0", ms_a, overlap_a);
    end
    bus_a.start = 1'b0;
    lat_mode = 0;
    repeat (2) @(negedge clk);
    $display("test_variable_latency: %0d writes, %0d mac_starts", wr_a.size(), ms_a);
  endtask

  task automatic test_spurious();
    bit ok;
    int s, bad;
    clear_a();
    lat_fixed = 3;
    spurious = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b1;
    s = cyc + 1;
    wait_done_a(400, ok);
    checks++;
    if (!ok || order_errs_a() != 0) begin
      errors++;
      $display("FAIL spurious_writes: done %0b writes %0d, required 1 and 18 in order", ok, wr_a.size());
    end
    bad = 0;
    foreach (gap_a[i]) if (gap_a[i] != 4) bad++;
    checks++;
    if (bad != 0 || gap_a.size() != 18) begin
      errors++;
      $display("FAIL spurious_gap: %0d early/late writes of %0d, required 0 of 18 (gap 4)", bad, gap_a.size());
    end
    checks++;
    if (done_cyc_a - s != 99) begin
      errors++;
      $display("FAIL spurious_latency: done after %0d edges, required 99", done_cyc_a - s);
    end
    spurious = 1'b0;
    lat_fixed = 1;
    bus_a.start = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_spurious: done after %0d edges", done_cyc_a - s);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s;
    clear_a();
    lat_fixed = 5;
    @(negedge clk);
    bus_a.start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_a.size() == 6 && ms_a == 7 && !bus_a.mac_start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus_a.feature_row !== 3'd2) begin
      errors++;
      $display("FAIL mid_reach_wait: reached %0b row %0d, required 1 and 2", ok, bus_a.feature_row);
    end
    #1;
    reset = 1'b0;
    bus_a.start = 1'b0;
    #1;
    checks++;
    if (outs_a() !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_async: outs %h, required 0 before next edge", outs_a());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_a();
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a() !== 24'h0 || rd_a.size() != 0 || ms_a != 0) begin
      errors++;
      $display("FAIL mid_reset_idle: outs %h reads %0d mac_starts %0d, required all 0", outs_a(), rd_a.size(), ms_a);
    end
    clear_a();
    lat_fixed = 1;
    bus_a.start = 1'b1;
    s = cyc + 1;
    wait_done_a(200, ok);
    checks++;
    if (!ok || order_errs_a() != 0 || done_cyc_a - s != 63 || rd_a.size() != 9) begin
      errors++;
      $display("FAIL mid_rerun: done %0b writes %0d latency %0d reads %0d, required 1 18 63 9",
               ok, wr_a.size(), done_cyc_a - s, rd_a.size());
    end
    bus_a.start = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset_mid: rerun writes %0d", wr_a.size());
  endtask

  task automatic test_sweep_1x1();
    bit ok;
    int s;
    rd_b.delete();
    wr_b.delete();
    done_cyc_b = -1;
    @(negedge clk);
    bus_b.start = 1'b1;
    s = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_b.done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || done_cyc_b - s != 5) begin
      errors++;
      $display("FAIL sweep_latency: done %0b after %0d edges, required 1 after 5", ok, done_cyc_b - s);
    end
    checks++;
    if (rd_b.size() != 2) begin
      errors++;
      $display("FAIL sweep_read_count: got %0d, required 2", rd_b.size());
    end else begin
      checks++;
      if (rd_b[0] != 13'h000 || rd_b[1] != 13'h200) begin
        errors++;
        $display("FAIL sweep_read_addrs: got %h %h, required 000 200", rd_b[0], rd_b[1]);
      end
    end
    checks++;
    if (wr_b.size() != 1 || (wr_b.size() == 1 && wr_b[0] != 0)) begin
      errors++;
      $display("FAIL sweep_write: %0d writes, required one at (0,0)", wr_b.size());
    end
    bus_b.start = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_sweep_1x1: reads %0d writes %0d", rd_b.size(), wr_b.size());
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_done_hold();
    test_variable_latency();
    test_spurious();
    test_reset_mid();
    test_sweep_1x1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
